// File: rtl/gpr_pkg.sv
// Shared types and constants for the integer register file and its snapshot engine.
// Provides width defaults, index/data typedefs, snapshot FSM states and a write-qualify helper.
package gpr_pkg;

    localparam int XLEN_DEF    = 64;
    localparam int NUM_GPR_DEF = 32;
    localparam int GPR_IDX_W   = 5;

    typedef logic [GPR_IDX_W-1:0] gpr_idx_t;
    typedef logic [XLEN_DEF-1:0]  gpr_data_t;

    typedef enum logic [1:0] {
        SNAP_IDLE,
        SNAP_DUMP,
        SNAP_DONE
    } snap_state_t;

    // A write only has architectural effect when it targets a non-zero index.
    function automatic logic wr_effective(input logic wen, input gpr_idx_t waddr);
        return wen && (waddr != '0);
    endfunction

endpackage

// File: rtl/gpr_snap_fsm.sv
// Snapshot sequencer: IDLE/DUMP/DONE state, beat index counter, valid/ready handshake and dirty tracking.
// Ports: clock, reset (sync, active-high), wen/waddr (write observation), snap_req/snap_ready in;
//        snap_idx, snap_busy, snap_valid, snap_last, snap_dirty, snap_done out.
module gpr_snap_fsm
    import gpr_pkg::*;
#(
    parameter int NUM_GPR = NUM_GPR_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wen,
    input  logic [GPR_IDX_W-1:0] waddr,
    input  logic                 snap_req,
    input  logic                 snap_ready,
    output logic [GPR_IDX_W-1:0] snap_idx,
    output logic                 snap_busy,
    output logic                 snap_valid,
    output logic                 snap_last,
    output logic                 snap_dirty,
    output logic                 snap_done
);

    localparam gpr_idx_t LAST_IDX = gpr_idx_t'(NUM_GPR - 1);

    snap_state_t state_q, state_d;
    gpr_idx_t    idx_q, idx_d;
    logic        sticky_q, sticky_d;

    logic wr_hit;
    logic accept;
    logic early_hit;
    logic same_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= SNAP_IDLE;
            idx_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sticky_d   = sticky_q;
        snap_valid = 1'b0;
        snap_busy  = 1'b0;
        snap_done  = 1'b0;
        accept     = 1'b0;
        early_hit  = 1'b0;
        same_hit   = 1'b0;
        wr_hit     = wr_effective(wen, waddr);

        unique case (state_q)
            SNAP_IDLE: begin
                if (snap_req) begin
                    state_d  = SNAP_DUMP;
                    idx_d    = '0;
                    sticky_d = 1'b0;
                end
            end
            SNAP_DUMP: begin
                snap_valid = 1'b1;
                snap_busy  = 1'b1;
                accept     = snap_ready;
                // Below idx: already streamed, image now stale.
                early_hit  = wr_hit && (waddr < idx_q);
                // Equal to idx on the accepting edge: the old value left.
                same_hit   = wr_hit && accept && (waddr == idx_q);
                if (early_hit || same_hit) begin
                    sticky_d = 1'b1;
                end
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = SNAP_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + gpr_idx_t'(1);
                    end
                end
            end
            SNAP_DONE: begin
                snap_busy = 1'b1;
                snap_done = 1'b1;
                state_d   = SNAP_IDLE;
            end
            default: begin
                state_d = SNAP_IDLE;
            end
        endcase
    end

    assign snap_idx   = idx_q;
    assign snap_last  = snap_valid && (idx_q == LAST_IDX);
    assign snap_dirty = snap_last && (sticky_q || early_hit || same_hit);

endmodule

// File: rtl/gpr_regfile_snapshot.sv
// Integer register file (x0 hardwired zero), two combinational read ports, one write port,
// plus a snapshot engine streaming all registers over a valid/ready beat interface.
// Ports: clock, reset (sync, active-high); rs1/rs2 addr in, data out; wen/waddr/wdata in;
//        snap_req/snap_ready in; snap_busy/valid/idx/data/last/dirty/done out.
// Build option: GPR_BYPASS_EN enables same-cycle write-first forwarding on the read ports.
module gpr_regfile_snapshot
    import gpr_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NUM_GPR = NUM_GPR_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [GPR_IDX_W-1:0] rs1_addr,
    output logic [XLEN-1:0]      rs1_data,
    input  logic [GPR_IDX_W-1:0] rs2_addr,
    output logic [XLEN-1:0]      rs2_data,
    input  logic                 wen,
    input  logic [GPR_IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic                 snap_req,
    output logic                 snap_busy,
    output logic                 snap_valid,
    input  logic                 snap_ready,
    output logic [GPR_IDX_W-1:0] snap_idx,
    output logic [XLEN-1:0]      snap_data,
    output logic                 snap_last,
    output logic                 snap_dirty,
    output logic                 snap_done
);

    logic [XLEN-1:0] regs [NUM_GPR];
    logic            wr_en;

    assign wr_en = wr_effective(wen, waddr);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
`ifdef GPR_BYPASS_EN
        if (wr_en && (waddr == rs1_addr)) begin
            rs1_data = wdata;
        end
        if (wr_en && (waddr == rs2_addr)) begin
            rs2_data = wdata;
        end
`endif
    end

    gpr_snap_fsm #(
        .NUM_GPR (NUM_GPR)
    ) u_fsm (
        .clock      (clock),
        .reset      (reset),
        .wen        (wen),
        .waddr      (waddr),
        .snap_req   (snap_req),
        .snap_ready (snap_ready),
        .snap_idx   (snap_idx),
        .snap_busy  (snap_busy),
        .snap_valid (snap_valid),
        .snap_last  (snap_last),
        .snap_dirty (snap_dirty),
        .snap_done  (snap_done)
    );

    // Live value, never bypassed; index 0 is always the zero register.
    assign snap_data = (snap_idx == '0) ? '0 : regs[snap_idx];

endmodule

// File: tb/tb_gpr_regfile_snapshot.sv
// Directed self-checking bench for gpr_regfile_snapshot.
// Covers reads/writes, x0, bypass behaviour, full dumps, stalls, dirty tracking and mid-dump reset.
module tb_gpr_regfile_snapshot;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, waddr, snap_idx;
    logic [63:0] rs1_data, rs2_data, wdata, snap_data;
    logic        wen, snap_req, snap_busy, snap_valid, snap_ready;
    logic        snap_last, snap_dirty, snap_done;

    logic [63:0] exp_reg [32];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    gpr_regfile_snapshot dut (
        .clock      (clock),
        .reset      (reset),
        .rs1_addr   (rs1_addr),
        .rs1_data   (rs1_data),
        .rs2_addr   (rs2_addr),
        .rs2_data   (rs2_data),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .snap_req   (snap_req),
        .snap_busy  (snap_busy),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .snap_idx   (snap_idx),
        .snap_data  (snap_data),
        .snap_last  (snap_last),
        .snap_dirty (snap_dirty),
        .snap_done  (snap_done)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
        if (a != 5'd0) exp_reg[a] = d;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        rs1_addr = 5'd5; rs2_addr = 5'd31;
        #1;
        checks++;
        if ({snap_valid, snap_busy, snap_last, snap_dirty, snap_done, snap_idx} !== 10'd0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0",
                {snap_valid, snap_busy, snap_last, snap_dirty, snap_done, snap_idx});
        end
        checks++;
        if ({rs1_data, rs2_data} !== 128'd0) begin
            errors++;
            $display("FAIL reset_regs got %h %h want 0", rs1_data, rs2_data);
        end
        for (int i = 0; i < 32; i++) exp_reg[i] = 64'd0;
    endtask

    task automatic test_write_read;
        write_reg(5'd5, 64'hDEAD_BEEF);
        rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_x5 got %h want %h", rs1_data, 64'hDEAD_BEEF);
        end
        write_reg(5'd0, 64'h1234);
        rs2_addr = 5'd0;
        #1;
        checks++;
        if (rs2_data !== 64'd0) begin
            errors++;
            $display("FAIL rd_x0 got %h want 0", rs2_data);
        end
    endtask

    task automatic test_bypass;
        logic [63:0] exp_same;
        write_reg(5'd7, 64'h11);
        wen = 1'b1; waddr = 5'd7; wdata = 64'h55; rs1_addr = 5'd7;
`ifdef GPR_BYPASS_EN
        exp_same = 64'h55;
`else
        exp_same = 64'h11;
`endif
        #1;
        checks++;
        if (rs1_data !== exp_same) begin
            errors++;
            $display("FAIL same_cycle_rd got %h want %h", rs1_data, exp_same);
        end
        tick();
        wen = 1'b0; exp_reg[7] = 64'h55;
        #1;
        checks++;
        if (rs1_data !== 64'h55) begin
            errors++;
            $display("FAIL next_cycle_rd got %h want 55", rs1_data);
        end
    endtask

    task automatic test_dump(input int wr_at, input logic [4:0] wa,
                             input logic [63:0] wd, input logic exp_dirty,
                             input string tag);
        snap_ready = 1'b1;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        for (int b = 0; b < 32; b++) begin
            if (b == wr_at) begin
                wen = 1'b1; waddr = wa; wdata = wd;
            end
            #1;
            checks++;
            if ({snap_valid, snap_busy, snap_idx} !== {2'b11, 5'(b)}) begin
                errors++;
                $display("FAIL %s_beat%0d_ctl got v%b b%b i%0d want v1 b1 i%0d",
                    tag, b, snap_valid, snap_busy, snap_idx, b);
            end
            checks++;
            if (snap_data !== exp_reg[b]) begin
                errors++;
                $display("FAIL %s_beat%0d_data got %h want %h", tag, b, snap_data, exp_reg[b]);
            end
            checks++;
            if (snap_last !== (b == 31)) begin
                errors++;
                $display("FAIL %s_beat%0d_last got %b want %b", tag, b, snap_last, b == 31);
            end
            checks++;
            if (snap_dirty !== ((b == 31) ? exp_dirty : 1'b0)) begin
                errors++;
                $display("FAIL %s_beat%0d_dirty got %b want %b", tag, b, snap_dirty,
                    (b == 31) ? exp_dirty : 1'b0);
            end
            tick();
            if (b == wr_at) begin
                wen = 1'b0;
                if (wa != 5'd0) exp_reg[wa] = wd;
            end
        end
        checks++;
        if ({snap_done, snap_busy, snap_valid} !== 3'b110) begin
            errors++;
            $display("FAIL %s_done got d%b b%b v%b want d1 b1 v0", tag, snap_done, snap_busy, snap_valid);
        end
        tick();
        checks++;
        if ({snap_done, snap_busy, snap_valid} !== 3'b000) begin
            errors++;
            $display("FAIL %s_idle got d%b b%b v%b want 0 0 0", tag, snap_done, snap_busy, snap_valid);
        end
    endtask

    task automatic test_stall;
        int exp_idx;
        int c;
        exp_idx = 0;
        c = 0;
        snap_req = 1'b1;
        tick();
        while (exp_idx < 32 && c < 200) begin
            snap_ready = (c % 4 == 0) || (c % 4 == 3);
            snap_req = (c == 5);
            #1;
            checks++;
            if ({snap_valid, snap_idx} !== {1'b1, 5'(exp_idx)} || snap_data !== exp_reg[exp_idx]) begin
                errors++;
                $display("FAIL stall_c%0d got v%b i%0d d%h want v1 i%0d d%h",
                    c, snap_valid, snap_idx, snap_data, exp_idx, exp_reg[exp_idx]);
            end
            tick();
            if (snap_ready) exp_idx++;
            c++;
        end
        snap_req = 1'b0;
        snap_ready = 1'b1;
        checks++;
        if (c >= 200) begin
            errors++;
            $display("FAIL stall_timeout got %0d beats want 32", exp_idx);
        end
        checks++;
        if (snap_done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done got %b want 1", snap_done);
        end
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        checks++;
        if ({snap_busy, snap_valid, snap_done} !== 3'b000) begin
            errors++;
            $display("FAIL req_in_done got b%b v%b d%b want 0 0 0", snap_busy, snap_valid, snap_done);
        end
        tick();
        checks++;
        if ({snap_busy, snap_valid} !== 2'b00) begin
            errors++;
            $display("FAIL no_queue got b%b v%b want 0 0", snap_busy, snap_valid);
        end
    endtask

    task automatic test_reset_mid_dump;
        snap_ready = 1'b1;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        repeat (15) tick();
        checks++;
        if (snap_idx !== 5'd15) begin
            errors++;
            $display("FAIL pre_reset_idx got %0d want 15", snap_idx);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rs1_addr = 5'd5; rs2_addr = 5'd31;
        #1;
        checks++;
        if ({snap_valid, snap_busy, snap_idx} !== 7'd0) begin
            errors++;
            $display("FAIL mid_reset_ctl got v%b b%b i%0d want 0 0 0", snap_valid, snap_busy, snap_idx);
        end
        checks++;
        if ({rs1_data, rs2_data} !== 128'd0) begin
            errors++;
            $display("FAIL mid_reset_regs got %h %h want 0", rs1_data, rs2_data);
        end
        for (int i = 0; i < 32; i++) exp_reg[i] = 64'd0;
        test_dump(-1, 5'd0, 64'd0, 1'b0, "post_reset");
    endtask

    initial begin
        reset = 1'b1;
        rs1_addr = '0; rs2_addr = '0; waddr = '0; wdata = '0;
        wen = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        for (int i = 1; i < 32; i++) write_reg(5'(i), 64'(i * 32'h100));
        test_dump(-1, 5'd0, 64'd0, 1'b0, "full");
        test_stall();
        test_dump(10, 5'd3, 64'hAA, 1'b1, "dirty_x3");
        test_dump(10, 5'd20, 64'hBB, 1'b0, "clean_x20");
        test_dump(31, 5'd31, 64'hCC, 1'b1, "same_last");
        test_reset_mid_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
